fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the team's 32x8 FIFO between N requesters.
- Each requester presents a valid/ready interface. The arbiter selects one requester per cycle, drives the FIFO w_en/d_in, and applies FIFO full as backpressure.
- Sits in the write-clock domain directly in front of the FIFO. Also keeps write and stall statistics for debug.

---
 rtl/fifo_wr_arbiter.sv | 109 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N valid/ready requesters; zero-latency write path.
// Define ARB_LOCK_EN to hold the grant on one requester until its req_last beat (contiguous packets).
module fifo_wr_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  input  logic                 fifo_full,
  output logic                 fifo_w_en,
  output logic [W-1:0]         fifo_d_in,
  output logic [$clog2(N)-1:0] grant_id,
  output logic [CW-1:0]        wr_count,
  output logic [CW-1:0]        stall_count
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_idx;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] nxt_ptr;
  logic          rr_hit;
  logic          gnt_hit;
  logic          xfer;

  // Scan downwards so the last hit written is the one closest to rr_ptr.
  always_comb begin
    int j;
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % N;
      if (req_valid[j]) begin
        rr_hit = 1'b1;
        rr_idx = PW'(j);
      end
    end
  end

`ifdef ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] lock_id;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      lock_id <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && xfer && !req_last[gnt_idx])
        lock_id <= gnt_idx;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && !req_last[gnt_idx]) state_nxt = LOCKED;
      LOCKED:  if (xfer && req_last[gnt_idx])  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_hit = rr_hit;
    gnt_idx = rr_idx;
    if (state == LOCKED) begin
      gnt_hit = req_valid[lock_id];
      gnt_idx = lock_id;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign gnt_hit     = rr_hit;
  assign gnt_idx     = rr_idx;
`endif

  // rst_n gates the grant so a beat presented during a reset edge is never consumed.
  assign xfer      = gnt_hit & ~fifo_full & rst_n;
  assign req_ready = xfer ? (N'(1) << gnt_idx) : '0;
  assign fifo_w_en = xfer;
  assign fifo_d_in = xfer ? req_data[gnt_idx*W +: W] : '0;
  assign nxt_ptr   = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      grant_id    <= '0;
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      if (xfer) begin
        rr_ptr   <= nxt_ptr;
        grant_id <= gnt_idx;
        wr_count <= wr_count + CW'(1);
      end
      if ((|req_valid) && fifo_full && (stall_count != {CW{1'b1}}))
        stall_count <= stall_count + CW'(1);
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed literal checks plus randomized traffic against a behavioural model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_w_en;
  logic [W-1:0]   fifo_d_in;
  logic [1:0]     grant_id;
  logic [CW-1:0]  wr_count;
  logic [CW-1:0]  stall_count;

  int n_chk  = 0;
  int n_fail = 0;

  fifo_wr_arbiter #(.N(N), .W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_w_en(fifo_w_en), .fifo_d_in(fifo_d_in), .grant_id(grant_id),
    .wr_count(wr_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: spec rules in plain integer form.
  int m_ptr, m_gid, m_wr, m_stall, m_lock;
  bit m_locked, m_init;
  initial begin
    m_ptr = 0; m_gid = 0; m_wr = 0; m_stall = 0; m_lock = 0; m_locked = 0; m_init = 0;
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    logic [W-1:0] ed;
    g = -1;
    if (rst_n && !fifo_full) begin
      if (m_locked) begin
        if (req_valid[m_lock]) g = m_lock;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    er = '0;
    ed = '0;
    if (g >= 0) begin
      er[g] = 1'b1;
      ed = req_data[g*W +: W];
    end
    check("m_req_ready", 32'(req_ready), 32'(er));
    check("m_fifo_w_en", 32'(fifo_w_en), 32'(g >= 0));
    check("m_fifo_d_in", 32'(fifo_d_in), 32'(ed));
    if (m_init) begin
      check("m_grant_id", 32'(grant_id), 32'(m_gid));
      check("m_wr_count", 32'(wr_count), 32'(m_wr));
      check("m_stall_count", 32'(stall_count), 32'(m_stall));
    end
    // Inputs stay stable until after the next posedge, so the next state can be taken now.
    if (!rst_n) begin
      m_ptr = 0; m_gid = 0; m_wr = 0; m_stall = 0; m_locked = 0; m_init = 1;
    end else begin
      if (req_valid != '0 && fifo_full && m_stall < (1 << CW) - 1) m_stall++;
      if (g >= 0) begin
        m_wr  = (m_wr + 1) % (1 << CW);
        m_gid = g;
        m_ptr = (g + 1) % N;
`ifdef ARB_LOCK_EN
        if (!m_locked && !req_last[g]) begin
          m_locked = 1;
          m_lock   = g;
        end else if (m_locked && req_last[g]) begin
          m_locked = 0;
        end
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] base;
    base      = 8'hA0;
    rst_n     = 1'b0;
    req_valid = '1;
    req_last  = '1;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = base + W'(i);

    // Reset held two clocks with every requester valid
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_w_en", 32'(fifo_w_en), 32'h0);
    check("rst_wr_count", 32'(wr_count), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_stall", 32'(stall_count), 32'h0);
    step();
    rst_n = 1'b1;

    // Round robin, all valid
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
      check("rr_d_in", 32'(fifo_d_in), 32'(8'hA0 + (k % 4)));
      step();
    end

    // Sparse: only 1 and 3
    req_valid = 4'b1010;
    @(negedge clk);
    check("rr_wr_count", 32'(wr_count), 32'd8);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("sparse_ready", 32'(req_ready), (k % 2 == 0) ? 32'b0010 : 32'b1000);
      step();
    end

    // Backpressure with requester 2
    req_valid = 4'b0100;
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_w_en", 32'(fifo_w_en), 32'h0);
      step();
    end
    fifo_full = 1'b0;
    @(negedge clk);
    check("bp_stall", 32'(stall_count), 32'd5);
    check("bp_release_ready", 32'(req_ready), 32'b0100);
    step();

    // Stall saturation at 2^CW-1
    req_valid = 4'b0001;
    fifo_full = 1'b1;
    repeat (20) step();
    @(negedge clk);
    check("sat_stall", 32'(stall_count), 32'd15);
    step();
    @(negedge clk);
    check("sat_stall_hold", 32'(stall_count), 32'd15);

    // wr_count wraps: 17 writes from reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    fifo_full = 1'b0;
    req_valid = '1;
    repeat (17) step();
    @(negedge clk);
    check("wrap_wr_count", 32'(wr_count), 32'd1);

`ifdef ARB_LOCK_EN
    // Requester 1 sends a 3-beat packet while requester 0 waits
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0011;
    req_last  = 4'b1101;
    @(negedge clk); check("lock_beat1", 32'(req_ready), 32'b0010); step();
    @(negedge clk); check("lock_beat2", 32'(req_ready), 32'b0010); step();
    req_last = 4'b1111;
    @(negedge clk); check("lock_beat3", 32'(req_ready), 32'b0010); step();
    @(negedge clk); check("lock_after", 32'(req_ready), 32'b0001); step();
`endif

    // Randomized traffic, model-checked every cycle
    for (int c = 0; c < 1500; c++) begin
      rst_n     = ($urandom_range(0, 79) != 0);
      req_valid = N'($urandom);
      req_last  = N'($urandom_range(0, 3) != 0 ? 4'hF : $urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      req_data  = ($urandom);
      step();
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
